// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: pipeline request/response and data-memory port of the MEM-stage LSU.
interface mem_stage_lsu_if #(parameter int AW = 10);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wd;
   logic [31:0]   mem_rd;
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wd
   );
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_wd
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: byte-addressed RV32I loads/stores onto a word memory, RMW for sub-word stores.
module mem_stage_lsu #(parameter int AW = 10) (
   input logic clk,
   input logic rst_n,
   mem_stage_lsu_if.slave bus
);
   typedef enum logic {IDLE, RMW_WR} state_t;
   state_t        state;
   logic [AW-1:0] idx_q;
   logic [31:0]   merged_q;
   logic [2:0]    f3;
   logic [1:0]    lane;
   logic [4:0]    sh;
   logic          acc, err, sw, sub_st;
   logic [31:0]   wmask, merged, ld;
   logic [7:0]    b_sel;
   logic [15:0]   h_sel;
   assign f3     = bus.req_funct3;
   assign lane   = bus.req_addr[1:0];
   assign sh     = {lane, 3'b000};
   assign err    = f3 == 3'b011 || f3[2:1] == 2'b11 || (bus.req_we && f3[2]) ||
                   (f3[1:0] == 2'b01 && lane[0]) || (f3 == 3'b010 && lane != 2'b00);
   assign acc    = bus.req_valid && state == IDLE;
   assign sw     = acc && bus.req_we && !err && f3 == 3'b010;
   assign sub_st = acc && bus.req_we && !err && f3 != 3'b010;
   // mem_rd only feeds registers, never an output directly
   assign wmask  = f3[0] ? 32'h0000_ffff : 32'h0000_00ff;
   assign merged = (bus.mem_rd & ~(wmask << sh)) | ((bus.req_wdata & wmask) << sh);
   assign b_sel  = 8'(bus.mem_rd >> sh);
   assign h_sel  = lane[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
   assign ld     = f3[1] ? bus.mem_rd :
                   f3[0] ? {{16{!f3[2] && h_sel[15]}}, h_sel} : {{24{!f3[2] && b_sel[7]}}, b_sel};
   assign bus.req_ready = state == IDLE;
   assign bus.mem_we    = rst_n && (state == RMW_WR || sw);
   assign bus.mem_wd    = state == RMW_WR ? merged_q : sw ? bus.req_wdata : '0;
   assign bus.mem_addr  = state == RMW_WR ? idx_q : bus.req_addr[AW+1:2];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx_q         <= '0;
         merged_q      <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         if (state == RMW_WR) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
         end else if (sub_st) begin
            state    <= RMW_WR;
            idx_q    <= bus.req_addr[AW+1:2];
            merged_q <= merged;
         end else if (acc) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= err;
            bus.rsp_rdata <= (err || bus.req_we) ? '0 : ld;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed stimulus with a response scoreboard for mem_stage_lsu.
module tb_mem_stage_lsu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int passes = 0;
   int total = 0;
   int run = 0;
   logic [32:0] q [$];
   logic [31:0] mem [1024];
   mem_stage_lsu_if #(.AW(10)) bus();
   mem_stage_lsu #(.AW(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.mem_rd = bus.mem_we ? 32'h0 : mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask
   always @(negedge clk) begin
      if (!rst_n) run = 0;
      else begin
         run = bus.rsp_valid ? run + 1 : 0;
         if (bus.rsp_valid) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
            end else begin
               logic [32:0] e;
               e = q.pop_front();
               chk("rsp_err", 32'(bus.rsp_err), 32'(e[32]));
               chk("rsp_rdata", bus.rsp_rdata, e[31:0]);
            end
         end
      end
   end
   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic push, input logic e_err, input logic [31:0] e_rd);
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_funct3 = f3;
      bus.req_addr = a;
      bus.req_wdata = wd;
      if (push) q.push_back({e_err, e_rd});
      #1;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[40] = 32'h0000_0006;
      mem[50] = 32'h1122_3344;
      for (int i = 1; i < 5; i++) mem[i] = 32'h1000_0000 * i + 32'(i);
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_funct3 = 3'b0;
      bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_wd", bus.mem_wd, 32'h0);
      rst_n = 1'b1;
      step();
      drive(1'b0, 3'b010, 32'd160, 32'h0, 1'b1, 1'b0, 32'h0000_0006);
      chk("lw_mem_addr", 32'(bus.mem_addr), 32'd40);
      chk("lw_mem_we", 32'(bus.mem_we), 32'd0);
      step();
      drive(1'b1, 3'b000, 32'd161, 32'h1234_56AB, 1'b1, 1'b0, 32'h0);
      chk("sb_acc_mem_we", 32'(bus.mem_we), 32'd0);
      step();
      chk("sb_rmw_ready", 32'(bus.req_ready), 32'd0);
      chk("sb_rmw_mem_we", 32'(bus.mem_we), 32'd1);
      chk("sb_rmw_mem_wd", bus.mem_wd, 32'h0000_AB06);
      chk("sb_rmw_mem_addr", 32'(bus.mem_addr), 32'd40);
      step();
      drive(1'b0, 3'b000, 32'd161, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFAB);
      step();
      drive(1'b0, 3'b100, 32'd161, 32'h0, 1'b1, 1'b0, 32'h0000_00AB);
      step();
      drive(1'b0, 3'b001, 32'd160, 32'h0, 1'b1, 1'b0, 32'hFFFF_AB06);
      step();
      drive(1'b1, 3'b001, 32'h103, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
      chk("sh_mis_mem_we", 32'(bus.mem_we), 32'd0);
      step();
      chk("sh_mis_ready", 32'(bus.req_ready), 32'd1);
      drive(1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 1'b1, 32'h0);
      step();
      drive(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
      step();
      drive(1'b1, 3'b100, 32'h4, 32'h55, 1'b1, 1'b1, 32'h0);
      chk("sbu_mem_we", 32'(bus.mem_we), 32'd0);
      step();
      drive(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      chk("sw_mem_we", 32'(bus.mem_we), 32'd1);
      chk("sw_mem_wd", bus.mem_wd, 32'hDEAD_BEEF);
      step();
      drive(1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      step();
      @(posedge clk);
      #1;
      for (int i = 1; i < 5; i++) begin
         drive(1'b0, 3'b010, 32'(4 * i), 32'h0, 1'b1, 1'b0, 32'h1000_0000 * i + 32'(i));
         step();
      end
      #5;
      chk("lw_run_len", 32'(run), 32'd4);
      @(posedge clk);
      #1;
      drive(1'b1, 3'b000, 32'd200, 32'h0000_00FF, 1'b0, 1'b0, 32'h0);
      step();
      chk("rst_rmw_mem_we", 32'(bus.mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_async_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      chk("rst_rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rel_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_kept", mem[50], 32'h1122_3344);
      @(posedge clk);
      #1;
      drive(1'b0, 3'b010, 32'd200, 32'h0, 1'b1, 1'b0, 32'h1122_3344);
      step();
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
